// File: rtl/router_1xn_core_if.sv
// Signal bundle between the router core, its single source agent and the N destination readers.
interface router_1xn_core_if #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 3
);
    logic [DATA_W-1:0]           d_in;
    logic                        pkt_valid;
    logic                        busy;
    logic                        error;
    logic [NUM_PORTS-1:0]        read_enb;
    logic [NUM_PORTS-1:0]        vld_out;
    logic [NUM_PORTS*DATA_W-1:0] d_out;

    modport master (output d_in, pkt_valid, read_enb,
                    input  busy, error, vld_out, d_out);
    modport slave  (input  d_in, pkt_valid, read_enb,
                    output busy, error, vld_out, d_out);
endinterface

// File: rtl/router_1xn_core.sv
// 1-to-N packet router: header-addressed write FSM with parity check feeding
// per-destination FIFOs that are flushed when their reader stalls too long.
//
// state       | meaning
// S_IDLE      | waiting for a header byte (pkt_valid=1)
// S_LOAD_DATA | storing payload/parity into the target FIFO
// S_DROP      | discarding a packet (bad destination or flushed target)
// S_CHECK     | one-cycle parity/error settle, source held off
module router_1xn_core #(
    parameter int DATA_W          = 8,
    parameter int NUM_PORTS       = 3,
    parameter int FIFO_DEPTH      = 16,
    parameter int SOFT_RST_CYCLES = 30
) (
    input  logic             clock,
    input  logic             resetn,
    router_1xn_core_if.slave bus
);
    localparam int ADDR_W    = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;
    localparam int PAD_PORTS = 1 << ADDR_W;
    localparam int PTR_W     = $clog2(FIFO_DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int TMR_W     = $clog2(SOFT_RST_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD_DATA, S_DROP, S_CHECK} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   dest_q, dest_d;
    logic [DATA_W-1:0]   parity_q, parity_d;
    logic                err_pend_q, err_pend_d;
    logic                error_q, error_d;

    logic [ADDR_W-1:0]   hdr_dest;
    logic                hdr_ok;
    logic                busy;
    logic                wr_req;
    logic [ADDR_W-1:0]   wr_port;
    logic [PAD_PORTS-1:0] full_pad, flush_pad;
    logic [NUM_PORTS-1:0] vld, flush, wr_en, rd_en;

    logic [CNT_W-1:0]    count_q  [NUM_PORTS];
    logic [PTR_W-1:0]    wr_ptr_q [NUM_PORTS];
    logic [PTR_W-1:0]    rd_ptr_q [NUM_PORTS];
    logic [TMR_W-1:0]    timer_q  [NUM_PORTS];
    logic [DATA_W-1:0]   dout_q   [NUM_PORTS];
    logic [DATA_W-1:0]   mem      [NUM_PORTS][FIFO_DEPTH];
    logic [NUM_PORTS*DATA_W-1:0] d_out_w;

    assign hdr_dest = bus.d_in[ADDR_W-1:0];
    assign hdr_ok   = (32'(hdr_dest) < 32'(NUM_PORTS));

    always_comb begin
        full_pad  = '0;
        flush_pad = '0;
        vld       = '0;
        flush     = '0;
        wr_en     = '0;
        rd_en     = '0;
        d_out_w   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            vld[i]       = (count_q[i] != '0);
            full_pad[i]  = (count_q[i] == CNT_W'(FIFO_DEPTH));
            flush[i]     = vld[i] && !bus.read_enb[i] &&
                           (timer_q[i] == TMR_W'(SOFT_RST_CYCLES - 1));
            flush_pad[i] = flush[i];
            wr_en[i]     = wr_req && (wr_port == ADDR_W'(i)) && !flush[i];
            rd_en[i]     = bus.read_enb[i] && vld[i] && !flush[i];
            d_out_w[i*DATA_W +: DATA_W] = dout_q[i];
        end
    end

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        parity_d   = parity_q;
        err_pend_d = err_pend_q;
        error_d    = 1'b0;
        busy       = 1'b0;
        wr_req     = 1'b0;
        wr_port    = dest_q;
        case (state_q)
            S_IDLE: begin
                busy    = hdr_ok && full_pad[hdr_dest];
                wr_port = hdr_dest;
                if (bus.pkt_valid && !busy) begin
                    if (!hdr_ok) begin
                        err_pend_d = 1'b1;
                        state_d    = S_DROP;
                    end else if (flush_pad[hdr_dest]) begin
                        err_pend_d = 1'b0;
                        state_d    = S_DROP;
                    end else begin
                        wr_req   = 1'b1;
                        parity_d = bus.d_in;
                        dest_d   = hdr_dest;
                        state_d  = S_LOAD_DATA;
                    end
                end
            end
            S_LOAD_DATA: begin
                busy = full_pad[dest_q];
                if (!busy) begin
                    wr_req = 1'b1;
                    if (bus.pkt_valid) begin
                        parity_d = parity_q ^ bus.d_in;
                    end else begin
                        error_d = (bus.d_in != parity_q);
                        state_d = S_CHECK;
                    end
                end
                // A stalled reader abandons the packet: drop the remainder silently.
                if (flush_pad[dest_q]) begin
                    err_pend_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = (!busy && !bus.pkt_valid) ? S_CHECK : S_DROP;
                end
            end
            S_DROP: begin
                if (!bus.pkt_valid) begin
                    error_d    = err_pend_q;
                    err_pend_d = 1'b0;
                    state_d    = S_CHECK;
                end
            end
            S_CHECK: begin
                busy    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            dest_q     <= '0;
            parity_q   <= '0;
            err_pend_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            dest_q     <= dest_d;
            parity_q   <= parity_d;
            err_pend_q <= err_pend_d;
            error_q    <= error_d;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                count_q[i]  <= '0;
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                timer_q[i]  <= '0;
                dout_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (flush[i]) begin
                    count_q[i]  <= '0;
                    wr_ptr_q[i] <= '0;
                    rd_ptr_q[i] <= '0;
                    timer_q[i]  <= '0;
                    dout_q[i]   <= '0;
                end else begin
                    if (wr_en[i])
                        wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                    if (rd_en[i]) begin
                        rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                        dout_q[i]   <= mem[i][rd_ptr_q[i]];
                    end
                    count_q[i] <= count_q[i] + CNT_W'(wr_en[i]) - CNT_W'(rd_en[i]);
                    timer_q[i] <= (vld[i] && !bus.read_enb[i]) ? timer_q[i] + TMR_W'(1) : '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_en[i])
                mem[i][wr_ptr_q[i]] <= bus.d_in;
        end
    end

    assign bus.busy    = busy;
    assign bus.error   = error_q;
    assign bus.vld_out = vld;
    assign bus.d_out   = d_out_w;
endmodule

// File: doc/router_1xn_core.md
# router_1xn_core

Parametrised 1-to-N packet router core: accepts byte-serial packets from a single source port, decodes the destination from the header, and buffers each packet into one of NUM_PORTS per-destination FIFOs. It computes and checks packet parity, flow-controls the source with busy, and flushes any output FIFO its reader abandons. It is the next generation of the 1x3 router, sitting between the source agent (d_in/pkt_valid/busy/error) and N destination readers (read_enb/vld_out/d_out).

## Interface
- DATA_W, 8: byte width of d_in and of each d_out lane.
- NUM_PORTS, 3: number of destinations, 2..16. The derived address width is ADDR_W = max(1, clog2(NUM_PORTS)).
- FIFO_DEPTH, 16: entries per destination FIFO; power of 2, at least 4.
- SOFT_RST_CYCLES, 30: consecutive unread-while-valid cycles before a FIFO is flushed.
- clock  in  1  single clock; all logic on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- d_in  in  DATA_W  packet byte from source.
- pkt_valid  in  1  high for header and payload bytes; low on the parity byte.
- busy  out  1  core cannot accept d_in this cycle; source holds d_in/pkt_valid.
- error  out  1  one-cycle pulse: parity mismatch or invalid destination.
- read_enb  in  NUM_PORTS  per-port pop request.
- vld_out  out  NUM_PORTS  per-port FIFO not empty.
- d_out  out  NUM_PORTS*DATA_W  per-port read data; lane i at bits [i*DATA_W +: DATA_W].

## Operation
- Packet format:
  - header: bits [ADDR_W-1:0] = destination; upper bits = length, informational only and not used for framing.
  - 0..n payload bytes.
  - parity byte = XOR of header and all payload bytes.
- Framing: pkt_valid is high on the header and payload bytes. The first byte accepted with pkt_valid low after the header is the parity byte.
- A byte is accepted on a rising edge where busy=0, except in IDLE with pkt_valid=0, where no byte is accepted.
- Write FSM:
  - IDLE:
    - pkt_valid=1, destination < NUM_PORTS, target FIFO not full: write header, parity accumulator <= header, go to LOAD_DATA.
    - Destination >= NUM_PORTS: consume header without writing, go to DROP with a pending error.
    - Target FIFO full: busy=1, stay in IDLE.
  - LOAD_DATA: target FIFO full gives busy=1 and no acceptance. Otherwise the byte is written.
    - If pkt_valid=1, XOR the byte into the accumulator and stay.
    - If pkt_valid=0, write the parity byte, register error <= (byte != accumulator), go to CHECK.
  - DROP: consume bytes without writing; busy=0. The byte with pkt_valid=0 goes to CHECK, with error <= 1 if the error is pending.
  - CHECK: exactly one cycle, busy=1, then IDLE.
- The parity byte is always stored in the FIFO, matching or not.
- busy is combinational from the FSM state, the full flags, and (in IDLE) the destination field of d_in.
- FIFO read: an edge with read_enb[i]=1 and vld_out[i]=1 loads the head into d_out lane i and advances the read pointer. read_enb on an empty FIFO is ignored, and d_out holds.
- vld_out[i] = (count[i] != 0), taken from registered pointers/count.
- A write and a read on the same FIFO in the same edge are both honoured. Full is judged before the edge, so a full FIFO rejects the write even when it is being read.
- Soft flush: timer[i] counts edges with vld_out[i]=1 and read_enb[i]=0, and clears otherwise. When it reaches SOFT_RST_CYCLES, FIFO i is emptied and d_out lane i and timer[i] are cleared.
  - If the FSM is in LOAD_DATA targeting port i, it moves to DROP with no pending error. The rest of the packet is consumed and discarded.
- Reset (async assert, sync release): FSM=IDLE; all pointers, counts, timers and the accumulator are 0; d_out=0, vld_out=0, busy=0, error=0. Reset mid-packet discards all stored and partial data.

## Timing
- Header accepted at edge N: vld_out[dest]=1 from after edge N.
- Pop at edge M: d_out valid after edge M, a one-cycle read latency.
- Parity accepted at edge P:
  - error, if set, is high for the cycle P..P+1 only.
  - busy=1 in that CHECK cycle.
  - The earliest next header is accepted at edge P+2.
- Minimum packet is 2 bytes: header with pkt_valid=1, then parity with pkt_valid=0.
- Flush fires on the SOFT_RST_CYCLES-th consecutive qualifying edge. vld_out[i]=0 from after that edge.

## Test plan
- NUM_PORTS=3: send header 0x0A (dest 2, len 2), payload 0x11 0x22, parity 0x39, reading port 2 continuously. Required: d_out lane 2 sequence 0x0A, 0x11, 0x22, 0x39; error stays 0; vld_out[2] falls after the 4th pop.
- Same packet with parity 0x38. Required: all 4 bytes stored; error=1 for exactly one cycle after the parity edge.
- FIFO_DEPTH=4, no reads, 6-byte packet to port 1. Required: busy=1 after 4 bytes are stored; source holds; after one pop, busy drops and the 5th byte is accepted.
- NUM_PORTS=3, header destination 3. Required: no vld_out rises; bytes are consumed through parity; one error pulse.
- vld_out[0]=1 with read_enb[0]=0 for 30 edges. Required: FIFO 0 is empty and d_out lane 0=0 after the 30th edge; with 29 edges then one pop, no flush.
- Assert resetn mid-payload. Required: all outputs are 0 immediately; after release, a new packet is routed correctly.
